sbox_layer_iter: RTL and testbench

- Sequential, parametrised successor of the combinational Ascon substitution layer.
- Applies the Ascon 5-bit S-box to all 64 columns of the 320-bit state, COLS_PER_CYCLE columns per clock, sharing that many S-box instances.
- Sits between the permutation's constant-addition and linear-diffusion stages and trades latency for area.
- Valid/ready handshakes on input and output allow back-pressure and back-to-back states.

---
 rtl/sbox_layer_iter.sv | 137 +++++++++++++
 tb/tb_sbox_layer_iter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_layer_iter.sv
// Ascon 5-bit S-box layer over the 320-bit state, COLS_PER_CYCLE columns per clock.
// Latency: valid_o rises NB_STEPS = 64/COLS_PER_CYCLE edges after the accepting edge.
// Backpressure: result held in HOLD until ready_i; ready_o follows ready_i there so a new state can enter on the same edge.

package sbox_layer_iter_pkg;
    // Five 64-bit words; word 0 carries x0 (the S-box index MSB).
    typedef logic [4:0][63:0] type_state;
endpackage

module sbox_layer_iter
    import sbox_layer_iter_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 8
) (
    input  logic      clock_i,
    input  logic      resetb_i,
    input  logic      valid_i,
    output logic      ready_o,
    input  type_state state_i,
    output logic      valid_o,
    input  logic      ready_i,
    output type_state state_o,
    output logic      busy_o
);

    localparam int NB_STEPS = 64 / COLS_PER_CYCLE;
    localparam int CNT_W    = (NB_STEPS > 1) ? $clog2(NB_STEPS) : 1;

    // Only power-of-two slice widths tile the 64 columns evenly.
    generate
        if (COLS_PER_CYCLE != 1  && COLS_PER_CYCLE != 2  && COLS_PER_CYCLE != 4 &&
            COLS_PER_CYCLE != 8  && COLS_PER_CYCLE != 16 && COLS_PER_CYCLE != 32 &&
            COLS_PER_CYCLE != 64) begin : g_bad_cols
            $error("sbox_layer_iter: COLS_PER_CYCLE must be 1, 2, 4, 8, 16, 32 or 64");
        end
    endgenerate

    // Ascon S-box, indexed by {x0,x1,x2,x3,x4}.
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fsm_t;

    fsm_t             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    type_state        work_q, work_d;
    type_state        work_sub;

    // Working register with the current slice of columns substituted; others pass through.
    always_comb begin
        work_sub = work_q;
        for (int c = 0; c < COLS_PER_CYCLE; c++) begin
            logic [5:0] col;
            logic [4:0] idx;
            logic [4:0] sub;
            col = 6'(int'(cnt_q) * COLS_PER_CYCLE + c);
            for (int w = 0; w < 5; w++) begin
                idx[4-w] = work_q[w][col];
            end
            sub = SBOX[idx];
            for (int w = 0; w < 5; w++) begin
                work_sub[w][col] = sub[4-w];
            end
        end
    end

    // Next-state, counter, working-register update and input-side handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        ready_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    work_d  = state_i;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                work_d = work_sub;
                if (cnt_q == CNT_W'(NB_STEPS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                // A consumer taking the result frees the register on the same edge.
                ready_o = ready_i;
                if (ready_i) begin
                    if (valid_i) begin
                        work_d  = state_i;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and working register; reset discards any partial result.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    // Outputs come straight from registers, so they are glitch-free.
    assign valid_o = (state_q == ST_HOLD);
    assign busy_o  = (state_q == ST_RUN);
    assign state_o = work_q;

endmodule

// File: tb/tb_sbox_layer_iter.sv
// Bench for sbox_layer_iter: one instance per legal COLS_PER_CYCLE (1..64), shared clock/reset.
// Directed latency/value/back-pressure/reset steps, then randomized traffic against a column-wise model.
// Random valid/ready on both sides; results checked in order through a queue scoreboard.

module tb_sbox_layer_iter;
    import sbox_layer_iter_pkg::*;

    localparam int NCFG = 7;

    localparam logic [4:0] SBOX_TB [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };

    logic      clk;
    logic      rst_n;
    logic      vld_i [NCFG];
    logic      rdy_i [NCFG];
    type_state st_i  [NCFG];
    logic      vld_o [NCFG];
    logic      rdy_o [NCFG];
    logic      bsy_o [NCFG];
    type_state st_o  [NCFG];

    int checks = 0;
    int errors = 0;

    // Instance g runs with 2**g columns per cycle.
    genvar g;
    generate
        for (g = 0; g < NCFG; g++) begin : g_dut
            sbox_layer_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
                .clock_i  (clk),
                .resetb_i (rst_n),
                .valid_i  (vld_i[g]),
                .ready_o  (rdy_o[g]),
                .state_i  (st_i[g]),
                .valid_o  (vld_o[g]),
                .ready_i  (rdy_i[g]),
                .state_o  (st_o[g]),
                .busy_o   (bsy_o[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Column-by-column table lookup on the whole state.
    function automatic type_state ref_sbox(input type_state s);
        type_state  r;
        logic [4:0] idx;
        logic [4:0] v;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            for (int w = 0; w < 5; w++) idx[4-w] = s[w][j];
            v = SBOX_TB[idx];
            for (int w = 0; w < 5; w++) r[w][j] = v[4-w];
        end
        return r;
    endfunction

    function automatic type_state rand_state();
        type_state s;
        for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input type_state obs, input type_state exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for valid_o on instance k; returns edges waited (bounded).
    task automatic wait_valid(input int k, output int n);
        n = 0;
        while (vld_o[k] !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
    endtask

    // One state through instance k with ready_i held high.
    task automatic run_one(input int k, input type_state st, input type_state exp,
                           input string tag, output type_state got);
        int n;
        st_i[k]  = st;
        vld_i[k] = 1'b1;
        rdy_i[k] = 1'b1;
        tick();
        vld_i[k] = 1'b0;
        chk_bit({tag, "_busy"}, bsy_o[k], 1'b1);
        wait_valid(k, n);
        chk_int({tag, "_latency"}, n, 64 >> k);
        got = st_o[k];
        chk_state({tag, "_result"}, got, exp);
        tick();
        chk_bit({tag, "_vld_drop"}, vld_o[k], 1'b0);
        chk_bit({tag, "_idle_rdy"}, rdy_o[k], 1'b1);
        chk_bit({tag, "_idle_busy"}, bsy_o[k], 1'b0);
        chk_state({tag, "_kept"}, st_o[k], got);
    endtask

    initial begin
        type_state zero_exp, ones_in, ones_exp, tv, got1, got8, got64, stA, stB, r;
        type_state exp_q[$];
        int        n, sent, recv, nst, cyc;
        logic      acc, fire;

        rst_n = 1'b0;
        for (int k = 0; k < NCFG; k++) begin
            vld_i[k] = 1'b0;
            rdy_i[k] = 1'b0;
            st_i[k]  = '0;
        end

        // Reset values of every instance.
        #12;
        for (int k = 0; k < NCFG; k++) begin
            chk_bit("rst_valid", vld_o[k], 1'b0);
            chk_bit("rst_busy", bsy_o[k], 1'b0);
            chk_bit("rst_ready", rdy_o[k], 1'b1);
            chk_state("rst_state", st_o[k], '0);
        end
        rst_n = 1'b1;

        // All-zero input, C=8: every column maps 0 -> 0x04, i.e. only word 2 set.
        zero_exp    = '0;
        zero_exp[2] = '1;
        run_one(3, '0, zero_exp, "zero_c8", r);

        // Known vector across C=8, 1, 64; results must agree with the model and each other.
        tv[0] = 64'h8040_0c06_0000_0000;
        tv[1] = 64'h8a55_114d_1cb6_a9a2;
        tv[2] = 64'hbe26_3d4d_7aec_aa0f;
        tv[3] = 64'h4ed0_ec0b_98c5_29b7;
        tv[4] = 64'hc8cd_df37_bcd0_284a;
        run_one(3, tv, ref_sbox(tv), "tv_c8", got8);
        run_one(0, tv, ref_sbox(tv), "tv_c1", got1);
        run_one(6, tv, ref_sbox(tv), "tv_c64", got64);
        chk_state("tv_c1_vs_c8", got1, got8);
        chk_state("tv_c64_vs_c8", got64, got8);

        // All-ones, C=16: index 31 -> 0x17, so only word 1 is cleared.
        ones_in     = '1;
        ones_exp    = '1;
        ones_exp[1] = '0;
        run_one(4, ones_in, ones_exp, "ones_c16", r);

        // Back-pressure on C=8: result held for 20 cycles, new state offered but refused.
        stA = rand_state();
        stB = rand_state();
        st_i[3]  = stA;
        vld_i[3] = 1'b1;
        rdy_i[3] = 1'b0;
        tick();
        vld_i[3] = 1'b0;
        wait_valid(3, n);
        chk_int("bp_latency", n, 8);
        st_i[3]  = stB;
        vld_i[3] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk_bit("bp_hold_valid", vld_o[3], 1'b1);
            chk_bit("bp_hold_ready", rdy_o[3], 1'b0);
            chk_state("bp_hold_state", st_o[3], ref_sbox(stA));
            tick();
        end
        rdy_i[3] = 1'b1;
        #1;
        chk_bit("bp_ready_follow", rdy_o[3], 1'b1);
        tick();
        vld_i[3] = 1'b0;
        chk_bit("bp_b2b_valid", vld_o[3], 1'b0);
        chk_bit("bp_b2b_busy", bsy_o[3], 1'b1);
        wait_valid(3, n);
        chk_int("bp_b2b_latency", n, 8);
        chk_state("bp_b2b_result", st_o[3], ref_sbox(stB));
        tick();
        chk_bit("bp_idle_valid", vld_o[3], 1'b0);

        // Reset during RUN on C=4 at step 7, then a normal run.
        st_i[2]  = rand_state();
        vld_i[2] = 1'b1;
        rdy_i[2] = 1'b1;
        tick();
        vld_i[2] = 1'b0;
        repeat (7) tick();
        chk_bit("mid_busy", bsy_o[2], 1'b1);
        rst_n = 1'b0;
        #1;
        chk_bit("mid_rst_valid", vld_o[2], 1'b0);
        chk_bit("mid_rst_busy", bsy_o[2], 1'b0);
        chk_bit("mid_rst_ready", rdy_o[2], 1'b1);
        chk_state("mid_rst_state", st_o[2], '0);
        #1;
        rst_n = 1'b1;
        stA = rand_state();
        run_one(2, stA, ref_sbox(stA), "post_rst_c4", r);

        // Randomized traffic on every configuration, ~1000 states in total.
        for (int k = 0; k < NCFG; k++) begin
            nst  = (k < NCFG - 1) ? 143 : 142;
            sent = 0;
            recv = 0;
            cyc  = 0;
            acc  = 1'b0;
            exp_q.delete();
            vld_i[k] = 1'b0;
            rdy_i[k] = 1'b0;
            tick();
            while (recv < nst && cyc < 40000) begin
                if (!vld_i[k] || acc) begin
                    if (sent < nst && $urandom_range(3) != 0) begin
                        vld_i[k] = 1'b1;
                        st_i[k]  = rand_state();
                    end else begin
                        vld_i[k] = 1'b0;
                    end
                end
                rdy_i[k] = ($urandom_range(3) != 0);
                #1;
                acc  = vld_i[k] && rdy_o[k];
                fire = vld_o[k] && rdy_i[k];
                if (fire) begin
                    chk_bit("rnd_unexpected_out", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) chk_state("rnd_result", st_o[k], exp_q.pop_front());
                    recv++;
                end
                if (acc) begin
                    exp_q.push_back(ref_sbox(st_i[k]));
                    sent++;
                end
                tick();
                cyc++;
            end
            vld_i[k] = 1'b0;
            rdy_i[k] = 1'b0;
            chk_int("rnd_received", recv, nst);
            chk_int("rnd_sent", sent, nst);
            chk_int("rnd_leftover", exp_q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
